qspi_sram_engine: RTL and testbench
===================================

// Module: qspi_sram_engine
// PURPOSE
//  Parametrised SPI/QSPI serial-SRAM transfer engine, successor to the fixed 32-bit QSPI shifter.
//  Accepts one read or write command per valid/ready handshake and serialises opcode, address,
//  dummy and data slots onto SIO. Transfers 1..DATA_BYTES bytes. Runtime 1-bit (SPI) or 4-bit (SQI) mode.
//  Sits between the bus-side SRAM controller and the pad ring; the pad ring builds the SIO inouts.
// PARAMETERS
//  ADDR_BITS     24     address width sent on the wire; must be a multiple of 4
//  DATA_BYTES    4      maximum bytes per transfer; data ports are 8*DATA_BYTES wide
//  DUMMY_CYCLES  2      dummy slots between address and read data, quad mode only
//  CS_GAP        2      minimum clk cycles in GAP state with cs_n high; must be >= 1
//  WRITE_OP      8'h02  write opcode
//  READ_OP       8'h03  read opcode
// PORTS
//  clk        in   1              system clock; SCK = clk/2
//  reset      in   1              synchronous, active-high reset
//  cmd_valid  in   1              command request
//  cmd_ready  out  1              engine idle, command accepted when cmd_valid && cmd_ready
//  cmd_we     in   1              1 = write, 0 = read
//  cmd_quad   in   1              1 = SQI (4-bit), 0 = SPI (1-bit)
//  cmd_addr   in   ADDR_BITS      start address
//  cmd_len    in   clog2(DB+1)    byte count; 0 or >DATA_BYTES is treated as DATA_BYTES
//  cmd_wdata  in   8*DATA_BYTES   write data; byte k = [8k+7:8k], byte 0 sent first
//  rsp_valid  out  1              one-cycle pulse at end of every transfer
//  rsp_rdata  out  8*DATA_BYTES   read data, same byte order; unreceived bytes are 0; 0 for writes
//  busy       out  1              high from acceptance to end of GAP
//  cs_n       out  1              chip select, active low
//  sck        out  1              serial clock
//  sio_out    out  4              SIO drive values
//  sio_oe     out  4              per-line output enable
//  sio_in     in   4              SIO sampled values
// BEHAVIOUR
//  - Reset values: cs_n=1, sck=0, sio_oe=0, sio_out=0, cmd_ready=1, rsp_valid=0, rsp_rdata=0, busy=0.
//    Reset mid-transfer aborts at once (next edge) with no rsp_valid.
//  - cmd_ready = (state==IDLE). Mode, we, addr, len and wdata are latched at acceptance (cycle 0).
//  - FSM: IDLE -> CMD -> ADDR -> [DUMMY, quad read only] -> WDATA|RDATA -> GAP -> IDLE.
//  - Slot timing: slot n occupies cycles 1+2n (sck=0, sio_out updated) and 2+2n (sck=1).
//    sio_in is sampled on the clk edge that ends the sck-high cycle. cs_n=0 from cycle 1 through cycle 2N.
//  - Quad mode: each slot carries a nibble, MSB nibble first, on sio[3:0].
//    Slot counts: CMD 2, ADDR ADDR_BITS/4, DUMMY DUMMY_CYCLES (reads only), data 2*len.
//    sio_oe=4'hF in CMD/ADDR/WDATA and 4'h0 in DUMMY/RDATA (turnaround).
//  - SPI mode: each slot carries one bit, MSB first. TX on sio[0], RX from sio[1]; no dummy slots.
//    sio_oe=4'b1101 with sio_out[3:2]=2'b11 (WP#/HOLD# held high).
//    Slot counts: CMD 8, ADDR ADDR_BITS, data 8*len.
//  - Cycle 1+2N: cs_n=1, sck=0, sio_oe=0, rsp_valid=1, rsp_rdata updated.
//    GAP lasts CS_GAP cycles starting at 1+2N; cmd_ready=1 at 1+2N+CS_GAP. cs_n high >= CS_GAP+1 cycles.
//  - rsp_rdata holds until the next rsp_valid. busy = !cmd_ready.
//  - Address counters and byte counters do not wrap; the device handles sequential-mode wrap.
// TESTING
//  1 Quad write, addr 0x00014D, len 4, wdata 0x00000064 -> sio_out nibbles 0,2,0,0,0,1,4,D,6,4,0,0,0,0,0,0;
//    cs_n low exactly 32 clk; one rsp_valid pulse.
//  2 Quad read, addr 0x00006F, len 2, model returns 0xA5 then 0x3C -> sio_oe 0 from slot 8;
//    cs_n low 28 clk; rsp_rdata=0x00003CA5.
//  3 SPI write, len 1, addr 0x000001, wdata 0x81 -> 40 slots (80 clk) on sio[0]; sio_oe=4'b1101 throughout.
//  4 cmd_len=0 and cmd_len=7 (DATA_BYTES=4) -> each performs a 4-byte transfer.
//  5 cmd_valid held for two commands -> second cs_n fall >= CS_GAP+1 clk after first cs_n rise;
//    cmd_ready low while busy.
//  6 reset asserted at slot 5 of a quad read -> next cycle cs_n=1, sio_oe=0, cmd_ready=1; no rsp_valid.

Source files
------------

// File: rtl/qspi_sram_engine.sv
// SPI/SQI serial-SRAM transfer engine: one read or write per command handshake,
// serialising opcode, address, dummy and data slots onto SIO with SCK = clk/2.
module qspi_sram_engine #(
    parameter int         ADDR_BITS    = 24,
    parameter int         DATA_BYTES   = 4,
    parameter int         DUMMY_CYCLES = 2,
    parameter int         CS_GAP       = 2,
    parameter logic [7:0] WRITE_OP     = 8'h02,
    parameter logic [7:0] READ_OP      = 8'h03,
    localparam int        LEN_W        = $clog2(DATA_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic                    cmd_quad,
    input  logic [ADDR_BITS-1:0]    cmd_addr,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic [8*DATA_BYTES-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    busy,
    output logic                    cs_n,
    output logic                    sck,
    output logic [3:0]              sio_out,
    output logic [3:0]              sio_oe,
    input  logic [3:0]              sio_in
);

    // state   | meaning
    // S_IDLE  | waiting for a command, cmd_ready high
    // S_CMD   | opcode slots
    // S_ADDR  | address slots
    // S_DUMMY | quad-read turnaround slots, SIO released
    // S_WDATA | write data slots
    // S_RDATA | read data slots, sampling SIO
    // S_GAP   | cs_n high recovery time after a transfer
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_GAP
    } state_t;

    localparam int DW = 8 * DATA_BYTES;
    localparam int FW = 8 + ADDR_BITS + DW;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CMAX = imax(imax(imax(8, ADDR_BITS), imax(DW, DUMMY_CYCLES)), CS_GAP);
    localparam int CW   = $clog2(CMAX + 1);

    state_t            state, state_n;
    logic              we_q, quad_q, phase;
    logic [LEN_W-1:0]  len_q, len_eff;
    logic [CW-1:0]     cnt;
    logic [FW-1:0]     tx_sr;
    logic [DW-1:0]     rx_sr, rx_next, rdata_n, wstream;
    logic              active, slot_end, tx_slot, last_slot;

    // Down-counter preload: slots remaining in the phase being entered, minus one.
    function automatic logic [CW-1:0] load_cnt(input state_t s, input logic quad,
                                               input logic [LEN_W-1:0] len);
        int n;
        n = 1;
        case (s)
            S_CMD:            n = quad ? 2 : 8;
            S_ADDR:           n = quad ? ADDR_BITS / 4 : ADDR_BITS;
            S_DUMMY:          n = DUMMY_CYCLES;
            S_WDATA, S_RDATA: n = quad ? 2 * int'(len) : 8 * int'(len);
            S_GAP:            n = CS_GAP;
            default:          n = 1;
        endcase
        return CW'(n - 1);
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign len_eff   = (cmd_len == '0 || int'(cmd_len) > DATA_BYTES) ? LEN_W'(DATA_BYTES) : cmd_len;
    assign active    = (state == S_CMD) || (state == S_ADDR) || (state == S_DUMMY) ||
                       (state == S_WDATA) || (state == S_RDATA);
    assign slot_end  = active && phase;
    assign last_slot = slot_end && (cnt == '0);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_n = S_CMD;
            S_CMD:   if (last_slot) state_n = S_ADDR;
            S_ADDR:  if (last_slot) begin
                         if (we_q)                              state_n = S_WDATA;
                         else if (quad_q && DUMMY_CYCLES > 0)   state_n = S_DUMMY;
                         else                                   state_n = S_RDATA;
                     end
            S_DUMMY: if (last_slot) state_n = S_RDATA;
            S_WDATA, S_RDATA: if (last_slot) state_n = S_GAP;
            S_GAP:   if (cnt == '0) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        cs_n    = 1'b1;
        sck     = 1'b0;
        sio_oe  = 4'h0;
        sio_out = 4'h0;
        tx_slot = (state == S_CMD) || (state == S_ADDR) || (state == S_WDATA);
        if (active) begin
            cs_n = 1'b0;
            sck  = phase;
            if (quad_q) begin
                sio_oe  = tx_slot ? 4'hF : 4'h0;
                sio_out = tx_slot ? tx_sr[FW-1 -: 4] : 4'h0;
            end else begin
                // WP#/HOLD# held high, sio[1] left as the MISO input
                sio_oe  = 4'b1101;
                sio_out = {2'b11, 1'b0, tx_slot & tx_sr[FW-1]};
            end
        end

        rx_next = quad_q ? {rx_sr[DW-5:0], sio_in} : {rx_sr[DW-2:0], sio_in[1]};
        rdata_n = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (k < int'(len_q)) rdata_n[8*k +: 8] = rx_next[8*(int'(len_q) - 1 - k) +: 8];
        end

        wstream = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            wstream[DW-1-8*k -: 8] = cmd_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            quad_q    <= 1'b0;
            len_q     <= '0;
            phase     <= 1'b0;
            cnt       <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_n;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    we_q   <= cmd_we;
                    quad_q <= cmd_quad;
                    len_q  <= len_eff;
                    tx_sr  <= {cmd_we ? WRITE_OP : READ_OP, cmd_addr, wstream};
                    rx_sr  <= '0;
                    phase  <= 1'b0;
                    cnt    <= load_cnt(S_CMD, cmd_quad, len_eff);
                end
                S_GAP: if (cnt != '0) cnt <= cnt - CW'(1);
                default: begin
                    phase <= ~phase;
                    if (phase) begin
                        tx_sr <= quad_q ? (tx_sr << 4) : (tx_sr << 1);
                        if (state == S_RDATA) rx_sr <= rx_next;
                        cnt <= (state_n != state) ? load_cnt(state_n, quad_q, len_q) : cnt - CW'(1);
                        if (state_n == S_GAP) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= we_q ? '0 : rdata_n;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_sram_engine.sv
// Scoreboard bench for qspi_sram_engine: a serial-SRAM device model answers reads,
// a monitor captures each SIO slot and compares against a bit-level reference model.
module tb_qspi_sram_engine;
    localparam int AB = 24, DB = 4, DUMMY = 2, GAP = 2;
    localparam int DW = 8 * DB, LW = $clog2(DB + 1);
    localparam logic [7:0] WOP = 8'h02, ROP = 8'h03;

    logic          clk = 1'b0, reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0, cmd_quad = 1'b0;
    logic [AB-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ready, rsp_valid, busy, cs_n, sck;
    logic [DW-1:0] rsp_rdata;
    logic [3:0]    sio_out, sio_oe;
    logic [3:0]    sio_in = 4'h0;

    int n_checks = 0, n_fail = 0;

    typedef struct {
        bit            we;
        bit            quad;
        logic [AB-1:0] addr;
        int            raw_len;
        int            len;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rbytes;
    } txn_t;

    txn_t       exp_q[$];
    txn_t       dev_q[$];
    logic [3:0] cap_out[$];
    logic [3:0] cap_oe[$];

    qspi_sram_engine dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_quad(cmd_quad), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .cs_n(cs_n), .sck(sck), .sio_out(sio_out), .sio_oe(sio_oe), .sio_in(sio_in)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int eff_len(input int raw);
        return (raw == 0 || raw > DB) ? DB : raw;
    endfunction

    function automatic int n_slots(input txn_t t);
        if (t.quad) return 2 + AB / 4 + (t.we ? 0 : DUMMY) + 2 * t.len;
        return 8 + AB + 8 * t.len;
    endfunction

    function automatic int n_tx(input txn_t t);
        if (t.quad) return 2 + AB / 4 + (t.we ? 2 * t.len : 0);
        return 8 + AB + (t.we ? 8 * t.len : 0);
    endfunction

    // i-th bit on the wire (MSB first): opcode, address, then data bytes in order
    function automatic logic tx_bit(input txn_t t, input int i);
        logic [7:0] op;
        int j;
        op = t.we ? WOP : ROP;
        if (i < 8) return op[7-i];
        if (i < 8 + AB) return t.addr[AB-1-(i-8)];
        j = i - 8 - AB;
        return t.wdata[8*(j/8) + 7 - (j%8)];
    endfunction

    function automatic logic rx_bit(input txn_t t, input int i);
        if (i >= DW) return 1'b0;
        return t.rbytes[8*(i/8) + 7 - (i%8)];
    endfunction

    function automatic void exp_slot(input txn_t t, input int i,
                                     output logic [3:0] o, output logic [3:0] oe, output logic [3:0] m);
        o = 4'h0;
        if (t.quad) begin
            oe = 4'h0; m = 4'h0;
            if (i < n_tx(t)) begin
                oe = 4'hF; m = 4'hF;
                for (int b = 0; b < 4; b++) o[3-b] = tx_bit(t, 4*i + b);
            end
        end else begin
            oe = 4'b1101; m = 4'b1100; o = 4'b1100;
            if (i < n_tx(t)) begin
                m = 4'b1101;
                o[0] = tx_bit(t, i);
            end
        end
    endfunction

    function automatic logic [DW-1:0] exp_rdata(input txn_t t);
        logic [DW-1:0] r;
        r = '0;
        if (!t.we) for (int k = 0; k < t.len; k++) r[8*k +: 8] = t.rbytes[8*k +: 8];
        return r;
    endfunction

    function automatic txn_t mk(input bit we, input bit quad, input logic [AB-1:0] addr,
                                input int raw, input logic [DW-1:0] wd, input logic [DW-1:0] rb);
        txn_t t;
        t.we = we; t.quad = quad; t.addr = addr; t.raw_len = raw;
        t.len = eff_len(raw); t.wdata = wd; t.rbytes = rb;
        return t;
    endfunction

    // ---------------- serial SRAM device ----------------
    initial begin : device
        txn_t d;
        int   slot, ds, j;
        bit   have;
        slot = 0; have = 0;
        forever begin
            @(negedge clk);
            if (cs_n || reset) begin
                slot = 0; have = 0;
                sio_in = 4'($urandom);
            end else if (!sck) begin
                if (slot == 0 && dev_q.size() > 0) begin
                    d = dev_q.pop_front();
                    have = 1;
                end
                sio_in = 4'($urandom);
                if (have && !d.we) begin
                    ds = d.quad ? 2 + AB / 4 + DUMMY : 8 + AB;
                    j  = slot - ds;
                    if (j >= 0) begin
                        if (d.quad) for (int b = 0; b < 4; b++) sio_in[3-b] = rx_bit(d, 4*j + b);
                        else        sio_in[1] = rx_bit(d, j);
                    end
                end
                slot++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        txn_t       t;
        int         cs_low, hi, gap_t, busy_bad, ns, bad;
        bit         track, prev_cs;
        logic [3:0] eo, eoe, em;
        cs_low = 0; hi = 100; gap_t = 0; busy_bad = 0; track = 0; prev_cs = 1;
        forever begin
            @(negedge clk);
            if (reset) begin
                cap_out.delete(); cap_oe.delete();
                cs_low = 0; busy_bad = 0; track = 0;
            end
            if (busy !== !cmd_ready) busy_bad++;
            if (!cs_n && cmd_ready) busy_bad++;
            if (cs_n) hi++;
            else begin
                if (prev_cs) check("cs_gap_ge_csgap_plus1", hi >= GAP + 1, 1'b1);
                hi = 0;
                cs_low++;
                if (!sck) begin
                    cap_out.push_back(sio_out);
                    cap_oe.push_back(sio_oe);
                end
            end
            prev_cs = cs_n;
            if (track && !reset) begin
                gap_t++;
                if (cmd_ready) begin
                    check("ready_after_rsp", gap_t, GAP);
                    track = 0;
                end
            end
            if (rsp_valid) begin
                check("rsp_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    t  = exp_q.pop_front();
                    ns = n_slots(t);
                    check("rsp_first_gap_cycle", hi, 1);
                    check("cs_low_cycles", cs_low, 2 * ns);
                    check("slot_count", cap_out.size(), ns);
                    bad = 0;
                    for (int i = 0; i < cap_out.size() && i < ns; i++) begin
                        exp_slot(t, i, eo, eoe, em);
                        if (cap_oe[i] !== eoe || ((cap_out[i] ^ eo) & em) !== 4'h0) bad++;
                    end
                    check("slot_values", bad, 0);
                    check("rdata", rsp_rdata, exp_rdata(t));
                    check("busy_vs_ready", busy_bad, 0);
                end
                cap_out.delete(); cap_oe.delete();
                cs_low = 0; busy_bad = 0; gap_t = 0; track = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input txn_t t, input bit hold);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 5000);
        check("issue_ready", cmd_ready, 1'b1);
        cmd_we    = t.we;
        cmd_quad  = t.quad;
        cmd_addr  = t.addr;
        cmd_len   = LW'(t.raw_len);
        cmd_wdata = t.wdata;
        cmd_valid = 1'b1;
        exp_q.push_back(t);
        dev_q.push_back(t);
        @(posedge clk);
        #1;
        check("ready_drops_on_accept", cmd_ready, 1'b0);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", exp_q.size(), 0);
    endtask

    initial begin : stim
        int   n;
        txn_t t;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_sio_oe", sio_oe, 4'h0);
        check("rst_sio_out", sio_out, 4'h0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;

        issue(mk(1, 1, 24'h00014D, 4, 32'h0000_0064, 32'h0), 0);
        wait_idle();
        issue(mk(0, 1, 24'h00006F, 2, $urandom, {16'($urandom), 16'h3CA5}), 0);
        wait_idle();
        check("t2_rdata", rsp_rdata, 32'h0000_3CA5);
        issue(mk(1, 0, 24'h000001, 1, {24'($urandom), 8'h81}, 32'h0), 0);
        wait_idle();
        issue(mk(1, 1, AB'($urandom), 0, $urandom, 32'h0), 0);
        wait_idle();
        issue(mk(0, 0, AB'($urandom), 7, 32'h0, $urandom), 0);
        wait_idle();

        issue(mk(0, 1, AB'($urandom), 3, 32'h0, $urandom), 1);
        issue(mk(1, 0, AB'($urandom), 2, $urandom, 32'h0), 0);
        wait_idle();

        // abort a quad read during slot 5
        issue(mk(0, 1, AB'($urandom), 4, 32'h0, $urandom), 0);
        n = 0;
        while (cap_out.size() < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_slot5", cap_out.size(), 6);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_cs_n", cs_n, 1'b1);
        check("abort_sio_oe", sio_oe, 4'h0);
        check("abort_cmd_ready", cmd_ready, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rsp_rdata", rsp_rdata, '0);
        reset = 1'b0;
        dev_q.delete();
        repeat (6) @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            t = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AB'($urandom),
                   $urandom_range(0, 7), $urandom, $urandom);
            issue(t, $urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
